// File: rtl/rs232_pkg.sv
// rs232_pkg: shared parity codes, transmitter state encoding and frame sizing helper.
package rs232_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    localparam int TW       = 12;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    function automatic int frame_bits(input int databits, input int parity, input int stopbits);
        return 1 + databits + ((parity != PAR_NONE) ? 1 : 0) + stopbits;
    endfunction

endpackage

// File: rtl/rs232_fifo.sv
// rs232_fifo: synchronous FIFO; writes are blocked when full regardless of a same-edge read.
module rs232_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             we, re;

    assign full  = count == CAP;
    assign empty = count == '0;
    assign we    = wr & ~full;
    assign re    = rd & ~empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk)
        if (we) mem[wptr] <= wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (we) wptr <= wptr + 1'b1;
            if (re) rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, we} - {{AW{1'b0}}, re};
        end
    end
endmodule

// File: rtl/rs232_txq.sv
// rs232_txq: queued RS-232 transmitter with configurable baud divisor, word length, parity and stop bits.
module rs232_txq
    import rs232_pkg::*;
#(
    parameter int CLKDIV   = 1302,
    parameter int DATABITS = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               data,
    output logic                     rdy,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     TxD
);
    state_t                state, nxt;
    logic [TW-1:0]         tmr;
    logic [2:0]            bcnt;
    logic [DATABITS-1:0]   sh, head;
    logic                  par, pop, full, empty, bit_end, last_data, last_stop;

    rs232_fifo #(.WIDTH(DATABITS), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (start),
        .wdata (data[DATABITS-1:0]),
        .rd    (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bit_end   = tmr == TW'(CLKDIV - 1);
    assign last_data = bcnt == 3'(DATABITS - 1);
    assign last_stop = bcnt == 3'(STOPBITS - 1);

    always_ff @(posedge clk)
        if (!rst) state <= IDLE;
        else      state <= nxt;

    // pop is raised only where a frame may begin, so back-to-back frames need no idle cycle
    always_comb begin
        nxt = state;
        pop = 1'b0;
        case (state)
            IDLE:  if (!empty) begin nxt = START; pop = 1'b1; end
            START: if (bit_end) nxt = DATA;
            DATA:  if (bit_end && last_data) nxt = (PARITY != PAR_NONE) ? PAR : STOP;
            PAR:   if (bit_end) nxt = STOP;
            STOP:  if (bit_end && last_stop) begin nxt = empty ? IDLE : START; pop = ~empty; end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr  <= '0;
            bcnt <= '0;
            sh   <= '0;
            par  <= 1'b0;
        end else begin
            tmr <= (state == IDLE || bit_end) ? '0 : tmr + 1'b1;
            if (pop) begin
                sh   <= head;
                par  <= 1'b0;
                bcnt <= '0;
            end else if (bit_end) begin
                if (state == DATA) begin
                    sh  <= sh >> 1;
                    par <= par ^ sh[0];
                end
                bcnt <= (nxt != state) ? '0 : bcnt + 1'b1;
            end
        end
    end

    always_comb begin
        TxD  = (state == START) ? 1'b0 :
               (state == DATA)  ? sh[0] :
               (state == PAR)   ? ((PARITY == PAR_ODD) ? ~par : par) : 1'b1;
        rdy  = ~full;
        busy = (state != IDLE) | ~empty;
    end
endmodule

// File: tb/tb_rs232_txq.sv
// tb_rs232_txq: three transmitter configurations checked every cycle against a frame-level line model.
module tb_rs232_txq;
    localparam int CD [3] = '{4, 4, 1302};
    localparam int DB [3] = '{8, 7, 8};
    localparam int PA [3] = '{0, 1, 0};
    localparam int SB [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       st [3];
    logic [7:0] data = 8'h00;
    logic       rdy [3], busy [3], txd [3];
    logic [2:0] cnt [3];

    int nchk = 0;
    int nfail = 0;

    bit   mbuf_v;
    logic [7:0] mbuf [3][4];
    int   mhead [3], msize [3], mpos [3], mlen [3];
    bit   mact [3];
    bit   mfr [3][16];
    bit   fin, pop, wr, p;
    logic [7:0] b;

    always #5 clk = ~clk;

    rs232_txq #(.CLKDIV(4), .DATABITS(8), .PARITY(0), .STOPBITS(1), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .data(data),
        .rdy(rdy[0]), .busy(busy[0]), .count(cnt[0]), .TxD(txd[0]));
    rs232_txq #(.CLKDIV(4), .DATABITS(7), .PARITY(1), .STOPBITS(2), .DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .data(data),
        .rdy(rdy[1]), .busy(busy[1]), .count(cnt[1]), .TxD(txd[1]));
    rs232_txq u_c (
        .clk(clk), .rst(rst), .start(st[2]), .data(data),
        .rdy(rdy[2]), .busy(busy[2]), .count(cnt[2]), .TxD(txd[2]));

    // line model: a queue of bytes and the bit vector of the frame currently on the wire
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                msize[i] = 0; mhead[i] = 0; mact[i] = 1'b0; mpos[i] = 0;
            end else begin
                fin = mact[i] && (mpos[i] == mlen[i] * CD[i] - 1);
                pop = (!mact[i] || fin) && (msize[i] > 0);
                wr  = st[i] && (msize[i] < 4);
                if (fin) mact[i] = 1'b0;
                if (pop) begin
                    b = mbuf[i][mhead[i]];
                    mhead[i] = (mhead[i] + 1) % 4;
                    msize[i] = msize[i] - 1;
                    mlen[i] = 1 + DB[i] + ((PA[i] != 0) ? 1 : 0) + SB[i];
                    p = 1'b0;
                    for (int k = 0; k < 16; k++) mfr[i][k] = 1'b1;
                    mfr[i][0] = 1'b0;
                    for (int k = 0; k < DB[i]; k++) begin
                        mfr[i][1+k] = b[k];
                        p = p ^ b[k];
                    end
                    if (PA[i] != 0) mfr[i][1+DB[i]] = (PA[i] == 1) ? ~p : p;
                    mact[i] = 1'b1;
                    mpos[i] = 0;
                end else if (mact[i]) begin
                    mpos[i] = mpos[i] + 1;
                end
                if (wr) begin
                    mbuf[i][(mhead[i] + msize[i]) % 4] = data;
                    msize[i] = msize[i] + 1;
                end
            end
        end
    end

    task automatic chk(input int i);
        logic ex;
        ex = mact[i] ? mfr[i][mpos[i] / CD[i]] : 1'b1;
        nchk++;
        assert (txd[i] === ex) else begin nfail++; $error("FAIL txd%0d t=%0t got %b want %b", i, $time, txd[i], ex); end
        nchk++;
        assert (cnt[i] === 3'(msize[i])) else begin nfail++; $error("FAIL count%0d t=%0t got %0d want %0d", i, $time, cnt[i], msize[i]); end
        nchk++;
        assert (rdy[i] === (msize[i] < 4)) else begin nfail++; $error("FAIL rdy%0d t=%0t got %b want %b", i, $time, rdy[i], msize[i] < 4); end
        nchk++;
        assert (busy[i] === (mact[i] || msize[i] > 0)) else begin nfail++; $error("FAIL busy%0d t=%0t got %b want %b", i, $time, busy[i], mact[i] || msize[i] > 0); end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk(i);
    endtask

    task automatic wait_idle(input int i, input int lim, output int n);
        n = 0;
        while (busy[i] && n < lim) begin
            tick();
            n++;
        end
        nchk++;
        assert (busy[i] === 1'b0) else begin nfail++; $error("FAIL idle_timeout%0d busy got %b want 0", i, busy[i]); end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // 8N1 frame of 8'h55, latency and length
        st[0] = 1'b1; data = 8'h55;
        tick();
        st[0] = 1'b0;
        nchk++;
        assert (cnt[0] === 3'd1 && busy[0] === 1'b1 && txd[0] === 1'b1) else begin nfail++; $error("FAIL s1_write cnt=%0d busy=%b txd=%b want 1 1 1", cnt[0], busy[0], txd[0]); end
        tick();
        nchk++;
        assert (txd[0] === 1'b0 && cnt[0] === 3'd0) else begin nfail++; $error("FAIL s1_pop txd=%b cnt=%0d want 0 0", txd[0], cnt[0]); end
        wait_idle(0, 200, n);
        nchk++;
        assert (n == 40) else begin nfail++; $error("FAIL s1_len got %0d want 40", n); end

        // 7O2 frame of 8'hC3
        st[1] = 1'b1; data = 8'hC3;
        tick();
        st[1] = 1'b0;
        tick();
        nchk++;
        assert (txd[1] === 1'b0) else begin nfail++; $error("FAIL s2_start txd got %b want 0", txd[1]); end
        wait_idle(1, 200, n);
        nchk++;
        assert (n == 44) else begin nfail++; $error("FAIL s2_len got %0d want 44", n); end

        // five writes fill the FIFO, a sixth is dropped
        for (int k = 0; k < 5; k++) begin
            st[0] = 1'b1; data = 8'($urandom);
            tick();
        end
        nchk++;
        assert (cnt[0] === 3'd4 && rdy[0] === 1'b0) else begin nfail++; $error("FAIL s3_full cnt=%0d rdy=%b want 4 0", cnt[0], rdy[0]); end
        data = 8'($urandom);
        tick();
        nchk++;
        assert (cnt[0] === 3'd4) else begin nfail++; $error("FAIL s3_drop cnt got %0d want 4", cnt[0]); end

        // start held while full across the pop edge
        n = 0;
        while (cnt[0] == 3'd4 && n < 100) begin
            data = 8'($urandom);
            tick();
            n++;
        end
        st[0] = 1'b0;
        nchk++;
        assert (cnt[0] === 3'd3) else begin nfail++; $error("FAIL s4_popfull cnt got %0d want 3", cnt[0]); end
        wait_idle(0, 400, n);

        // reset mid-DATA aborts the frame
        st[0] = 1'b1; data = 8'hF0;
        tick();
        st[0] = 1'b0;
        repeat (11) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        nchk++;
        assert (txd[0] === 1'b1 && cnt[0] === 3'd0 && busy[0] === 1'b0 && rdy[0] === 1'b1) else begin nfail++; $error("FAIL s5_reset txd=%b cnt=%0d busy=%b rdy=%b want 1 0 0 1", txd[0], cnt[0], busy[0], rdy[0]); end
        st[0] = 1'b1; data = 8'h0F;
        tick();
        st[0] = 1'b0;
        tick();
        wait_idle(0, 200, n);
        nchk++;
        assert (n == 40) else begin nfail++; $error("FAIL s5_len got %0d want 40", n); end

        // random traffic on both fast configurations
        for (int k = 0; k < 800; k++) begin
            st[0] = ($urandom % 3) == 0;
            st[1] = ($urandom % 4) == 0;
            data = 8'($urandom);
            tick();
        end
        st[0] = 1'b0; st[1] = 1'b0;
        wait_idle(0, 400, n);
        wait_idle(1, 400, n);

        // default parameters, one 8'hA5 frame
        st[2] = 1'b1; data = 8'hA5;
        tick();
        st[2] = 1'b0;
        tick();
        nchk++;
        assert (txd[2] === 1'b0) else begin nfail++; $error("FAIL s6_start txd got %b want 0", txd[2]); end
        wait_idle(2, 20000, n);
        nchk++;
        assert (n == 13020) else begin nfail++; $error("FAIL s6_len got %0d want 13020", n); end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/rs232_txq.md
# rs232_txq

Parametrised RS-232 transmitter, the successor of the fixed 19200-bps 8N1 sender. It adds a configurable baud divisor, 5–8 data bits, optional odd/even parity, 1 or 2 stop bits, and a small transmit FIFO. Bytes queued by the CPU I/O port are sent back-to-back with no idle gap. It sits between the processor I/O decode and the TxD pin.

## Interface
Parameters:
- CLKDIV, 1302: clock cycles per bit (25 MHz / 19200). Legal range 2..4095.
- DATABITS, 8: data bits per frame, 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOPBITS, 1: 1 or 2.
- DEPTH, 4: FIFO entries, a power of 2 from 2 to 16.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request to enqueue `data`; accepted only when `rdy` = 1.
- data  in  8  byte to send; bits above DATABITS-1 are ignored.
- rdy  out  1  FIFO not full.
- busy  out  1  a frame is in progress or the FIFO is non-empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- TxD  out  1  serial line, idle high.

## Operation
- Write: on an edge where `start & rdy`, `data` is stored at the write pointer, and the pointer and `count` increment.
  - `start` while `rdy` = 0 is ignored; the byte is dropped and nothing else changes.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if `count` ≠ 0, pop the head entry into the shift register, go to START, and drive `TxD` = 0.
  - START → DATA after CLKDIV cycles. `TxD` = 0 throughout.
  - DATA: DATABITS bits, LSB first, each held CLKDIV cycles. Then go to PAR if PARITY ≠ 0, else STOP.
  - PAR: drive the parity bit for CLKDIV cycles.
    - Odd: the total count of ones (data + parity) is odd.
    - Even: the total is even.
  - STOP: `TxD` = 1 for STOPBITS×CLKDIV cycles. At the end:
    - if `count` ≠ 0, pop and go directly to START (no idle cycle);
    - else go to IDLE.
- Bit timer counts 0..CLKDIV-1 and wraps. The bit counter counts data or stop bits.
- Pop decrements `count`. A write and a pop on the same edge leave `count` unchanged, and both take effect.
- A write when the FIFO is full is blocked, even if a pop happens on the same edge.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset (`rst` = 0 at an edge) applies in any state, including mid-frame:
  - FIFO is emptied and the FSM returns to IDLE;
  - `TxD` = 1, `rdy` = 1, `busy` = 0, `count` = 0 from that edge on.
  - An aborted frame is not resumed.

## Timing
- All outputs are registered or decoded from registers. There is no combinational path from `start` or `data` to any output.
- Latency with an empty FIFO and FSM in IDLE:
  - write at edge N;
  - `count` = 1 and `busy` = 1 after edge N;
  - pop and `TxD` falls after edge N+1; `count` returns to 0 after edge N+1.
- Frame length is exactly CLKDIV×(1+DATABITS+(PARITY≠0)+STOPBITS) cycles. Default 8N1: 13020 cycles.
- `rdy` deasserts after the edge that makes `count` = DEPTH. It reasserts after the edge of the next pop.
- `busy` falls after the edge on which the final stop bit ends with an empty FIFO. `TxD` stays 1.

## Structure
- Package `rs232_pkg` holds:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the FSM state encoding;
  - a function returning frame length in bits.
- Sub-module `rs232_fifo` is a synchronous FIFO with ports clk, rst, wr, wdata, rd, rdata, count, full, empty and parameters WIDTH and DEPTH.
- The top level holds the bit timer, bit counter, shift register, parity accumulator and FSM.

## Test plan
Run all scenarios at CLKDIV = 4 unless stated.
1. Reset, then write 8'h55, 8N1. `TxD` falls 2 edges after the write. Bits: 0,1,0,1,0,1,0,1,0 then stop 1, each exactly 4 cycles. `busy` = 0 after 40 cycles of frame.
2. PARITY = 1, DATABITS = 7, STOPBITS = 2, write 8'hC3 (7 bits = 1000011). Parity bit = 0 (three ones → odd already). Two stop bits. Frame = 44 cycles.
3. DEPTH = 4: write 5 bytes on consecutive edges while idle.
   - The first is popped at once, so `count` peaks at 4 after the fifth write and `rdy` drops.
   - A sixth `start` is ignored.
   - Frames are contiguous: the stop bit of frame k is immediately followed by the start bit of frame k+1.
4. With FIFO full, assert `start` on the same edge as a pop. The byte is dropped and `count` = DEPTH-1 afterwards.
5. Assert reset mid-DATA of 8'hF0. `TxD` = 1, `count` = 0, `busy` = 0, `rdy` = 1 next cycle. Then write 8'h0F; its frame is complete and correct.
6. Default parameters: one 8'hA5 frame measures 13020 cycles from the `TxD` fall to the end of the stop bit.
